// File: rtl/uart8_rx_if.sv
// uart8_rx_if: bundle of the receiver's configuration, line and result signals.
//   baud_rate16 : 24-bit DDS increment, Fbaud*2^28/Fclk (16x oversample rate)
//   rxd         : asynchronous serial line, idle high
//   rxdata      : last correctly received byte
//   rxvalid     : one-clk pulse, new byte on rxdata
//   frame_err   : one-clk pulse, bad stop bit
//   busy        : receiver not idle
// master = the side that drives the line and the rate, slave = the receiver.
interface uart8_rx_if;
    logic [23:0] baud_rate16;
    logic        rxd;
    logic [7:0]  rxdata;
    logic        rxvalid;
    logic        frame_err;
    logic        busy;

    modport master (
        output baud_rate16, rxd,
        input  rxdata, rxvalid, frame_err, busy
    );

    modport slave (
        input  baud_rate16, rxd,
        output rxdata, rxvalid, frame_err, busy
    );
endinterface

// File: rtl/uart8_rx.sv
// uart8_rx: 8N1/8N2 UART receiver with 16x DDS oversampling and 2-of-3
// majority voting at mid-bit.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : uart8_rx_if.slave (baud_rate16, rxd in; rxdata, rxvalid,
//           frame_err, busy out)
//   STOPBITS : number of stop bits checked per frame, 1 or 2
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a falling edge on the synchronized line
// START     | inside the start bit; a decided 1 is a glitch
// DATA      | shifting in 8 data bits, LSB first
// STOP      | checking stop bit(s); returns to IDLE at mid stop bit
// WAIT_HIGH | after break/framing error, waits for a full high bit time
module uart8_rx #(
    parameter int STOPBITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    uart8_rx_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    // bit index of the last stop bit (start bit is index 0)
    localparam logic [3:0] LAST_IDX = 4'(8 + STOPBITS);

    state_t      state_q, state_d;
    logic        sync1_q, rxs_q, prev_q;
    logic [2:0]  vld_q;
    logic [23:0] acc_q, acc_d;
    logic        tick_q, tick_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        s7_q, s7_d, s8_q, s8_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  rxdata_q, rxdata_d;
    logic        rxvalid_q, rxvalid_d;
    logic        frame_err_q, frame_err_d;

    logic [24:0] sum;
    logic        decide, maj;

    assign sum    = {1'b0, acc_q} + {1'b0, bus.baud_rate16};
    assign decide = tick_q && (cnt_q[3:0] == 4'd9);
    assign maj    = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tick_d      = 1'b0;
        cnt_d       = cnt_q;
        s7_d        = s7_q;
        s8_d        = s8_q;
        shreg_d     = shreg_q;
        rxdata_d    = rxdata_q;
        rxvalid_d   = 1'b0;
        frame_err_d = 1'b0;

        if (state_q != IDLE) begin
            acc_d  = sum[23:0];
            tick_d = sum[24];
        end
        if (tick_q) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (tick_q && (cnt_q[3:0] == 4'd7)) s7_d = rxs_q;
        if (tick_q && (cnt_q[3:0] == 4'd8)) s8_d = rxs_q;

        case (state_q)
            IDLE: begin
                acc_d  = '0;
                tick_d = 1'b0;
                cnt_d  = '0;
                // vld_q[2] keeps a line that was already low at reset release
                // from looking like a falling edge
                if (vld_q[2] && prev_q && !rxs_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;
                end else if (tick_q && (cnt_q == 8'd15)) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    shreg_d = {maj, shreg_q[7:1]};
                end
                if (tick_q && (cnt_q == 8'd143)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (!maj) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                        acc_d       = '0;
                        tick_d      = 1'b0;
                        cnt_d       = '0;
                    end else if (cnt_q[7:4] == LAST_IDX) begin
                        rxdata_d  = shreg_q;
                        rxvalid_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                // any low sample restarts the full-bit high count from scratch
                if (!rxs_q) begin
                    acc_d  = '0;
                    tick_d = 1'b0;
                    cnt_d  = '0;
                end else if (tick_q && (cnt_q == 8'd15)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            prev_q      <= 1'b1;
            vld_q       <= '0;
            acc_q       <= '0;
            tick_q      <= 1'b0;
            cnt_q       <= '0;
            s7_q        <= 1'b1;
            s8_q        <= 1'b1;
            shreg_q     <= '0;
            rxdata_q    <= 8'h00;
            rxvalid_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= bus.rxd;
            rxs_q       <= sync1_q;
            prev_q      <= rxs_q;
            vld_q       <= {vld_q[1:0], 1'b1};
            acc_q       <= acc_d;
            tick_q      <= tick_d;
            cnt_q       <= cnt_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            shreg_q     <= shreg_d;
            rxdata_q    <= rxdata_d;
            rxvalid_q   <= rxvalid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.rxdata    = rxdata_q;
    assign bus.rxvalid   = rxvalid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart8_rx.sv
// tb_uart8_rx: directed frames into two receivers (STOPBITS = 1 and 2),
// with a per-cycle compare against a frame-level model of expected results.
module tb_uart8_rx;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart8_rx_if if1 ();
    uart8_rx_if if2 ();

    uart8_rx #(.STOPBITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    uart8_rx #(.STOPBITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    // One expected pulse per frame: absolute clock on which it is visible.
    typedef struct {
        int         at;
        bit         err;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[2][$];
    logic [7:0] last_byte[2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // {busy, frame_err, rxvalid, rxdata}
    function automatic logic [10:0] outs(input int d);
        if (d == 0) return {if1.busy, if1.frame_err, if1.rxvalid, if1.rxdata};
        return {if2.busy, if2.frame_err, if2.rxvalid, if2.rxdata};
    endfunction

    task automatic setline(input int sel, input logic v);
        if (sel == 0) if1.rxd = v;
        else          if2.rxd = v;
    endtask

    // Entered and left at posedge+1: line set just after edge N, held for n edges.
    task automatic drive(input int sel, input logic v, input int n);
        setline(sel, v);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bit b of a frame starting after edge c0 is sampled mid-bit; the deciding
    // bit's pulse is visible 164 clk into that bit (2 sync FFs + edge detect,
    // then the 10th tick of the bit, then one register stage).
    task automatic send_frame(input int sel, input logic [7:0] data,
                              input logic [1:0] stops, input int spike_bit);
        int  c0, nstop, kdec;
        bit  err;
        ev_t e;
        nstop = (sel == 0) ? 1 : 2;
        c0    = cyc;
        err   = 1'b0;
        kdec  = nstop - 1;
        for (int k = nstop - 1; k >= 0; k--) begin
            if (!stops[k]) begin
                err  = 1'b1;
                kdec = k;
            end
        end
        e.at   = c0 + 256 * (9 + kdec) + 164;
        e.err  = err;
        e.data = data;
        evq[sel].push_back(e);

        drive(sel, 1'b0, 256);
        chk("start_busy", 32'(outs(sel)[10]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                drive(sel, data[i], 129);
                drive(sel, ~data[i], 1);
                drive(sel, data[i], 126);
            end else begin
                drive(sel, data[i], 256);
            end
        end
        for (int k = 0; k < nstop; k++) drive(sel, stops[k], 256);
        chk("end_busy", 32'(outs(sel)[10]), 32'(err));
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic       ev;
            logic       ee;
            logic [10:0] o;
            ev = 1'b0;
            ee = 1'b0;
            o  = outs(d);
            if (!rst_n) begin
                evq[d].delete();
                last_byte[d] = 8'h00;
                chk(d == 0 ? "u1_rst_busy" : "u2_rst_busy", 32'(o[10]), 32'd0);
            end else if (evq[d].size() > 0 && evq[d][0].at == cyc) begin
                if (evq[d][0].err) ee = 1'b1;
                else begin
                    ev = 1'b1;
                    last_byte[d] = evq[d][0].data;
                end
                void'(evq[d].pop_front());
            end
            chk(d == 0 ? "u1_rxvalid"   : "u2_rxvalid",   32'(o[8]),   32'(ev));
            chk(d == 0 ? "u1_frame_err" : "u2_frame_err", 32'(o[9]),   32'(ee));
            chk(d == 0 ? "u1_rxdata"    : "u2_rxdata",    32'(o[7:0]), 32'(last_byte[d]));
        end
    end

    initial begin
        int c;
        last_byte[0] = 8'h00;
        last_byte[1] = 8'h00;
        rst_n = 1'b1;
        if1.rxd = 1'b1;
        if2.rxd = 1'b1;
        if1.baud_rate16 = 24'h100000;
        if2.baud_rate16 = 24'h100000;
        #2 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_rxdata", 32'(if1.rxdata), 32'h00);
        chk("reset_busy", 32'(if1.busy), 32'd0);
        rst_n = 1'b1;
        drive(0, 1'b1, 20);

        // single frame 0xA5
        send_frame(0, 8'hA5, 2'b11, -1);
        drive(0, 1'b1, 100);
        chk("a5_rxdata", 32'(if1.rxdata), 32'hA5);

        // 48-clk low glitch on an idle line
        c = cyc;
        drive(0, 1'b0, 48);
        drive(0, 1'b1, 12);
        chk("glitch_busy_mid", 32'(if1.busy), 32'd1);
        drive(0, 1'b1, 140);
        chk("glitch_busy_after", 32'(if1.busy), 32'd0);
        chk("glitch_rxdata", 32'(if1.rxdata), 32'hA5);

        // 0x3C with a 0 stop bit, line held low, then released
        send_frame(0, 8'h3C, 2'b00, -1);
        drive(0, 1'b0, 512);
        chk("brk_busy_low", 32'(if1.busy), 32'd1);
        drive(0, 1'b1, 240);
        chk("brk_busy_240", 32'(if1.busy), 32'd1);
        drive(0, 1'b1, 40);
        chk("brk_busy_280", 32'(if1.busy), 32'd0);
        chk("brk_rxdata", 32'(if1.rxdata), 32'hA5);

        // back-to-back with a single-clk spike at phase 7 of data bit 3 of 0x55
        send_frame(0, 8'h00, 2'b11, -1);
        send_frame(0, 8'h55, 2'b11, 3);
        send_frame(0, 8'h80, 2'b11, -1);
        drive(0, 1'b1, 50);
        chk("b2b_rxdata", 32'(if1.rxdata), 32'h80);

        // two stop bits: second stop 0, then both 1
        send_frame(1, 8'hFF, 2'b01, -1);
        drive(1, 1'b1, 300);
        chk("sb2_busy_after", 32'(if2.busy), 32'd0);
        chk("sb2_rxdata_kept", 32'(if2.rxdata), 32'h00);
        send_frame(1, 8'hFF, 2'b11, -1);
        drive(1, 1'b1, 50);
        chk("sb2_rxdata", 32'(if2.rxdata), 32'hFF);

        // reset during data bit 4 of 0x12
        drive(0, 1'b0, 256);
        for (int i = 0; i < 4; i++) drive(0, (8'h12 >> i) & 8'h01 ? 1'b1 : 1'b0, 256);
        drive(0, 1'b1, 120);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rxvalid", 32'(if1.rxvalid), 32'd0);
        chk("midrst_frame_err", 32'(if1.frame_err), 32'd0);
        chk("midrst_busy", 32'(if1.busy), 32'd0);
        chk("midrst_rxdata", 32'(if1.rxdata), 32'h00);
        setline(0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1'b0, 600);
        chk("low_after_rst_busy", 32'(if1.busy), 32'd0);
        drive(0, 1'b1, 300);
        send_frame(0, 8'h34, 2'b11, -1);
        drive(0, 1'b1, 50);
        chk("post_rst_rxdata", 32'(if1.rxdata), 32'h34);

        chk("pending_u1", 32'(evq[0].size()), 32'd0);
        chk("pending_u2", 32'(evq[1].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
